// File: rtl/r_clk_fwft_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : r_clk_fwft_module                                               |
// | Purpose  : Read-domain side of an async FIFO with first-word-fall-through  |
// |            prefetch from a registered-output RAM. Optional almost-empty    |
// |            flag enabled by macro R_ALMOST_EMPTY_EN.                        |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+

module two_ff_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

module r_clk_fwft_module #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_SIZE    = 8,
    parameter int AE_THRESHOLD = 2
) (
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    input  logic [DATA_SIZE-1:0]    r_mem_data,
    input  logic                    r_en,
    output logic                    r_mem_en,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [DATA_SIZE-1:0]    r_data,
    output logic                    r_valid,
    output logic                    r_empty,
    output logic                    r_almost_empty
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDRESS_SIZE:0] r_bin;
    logic [ADDRESS_SIZE:0] w_rq2_wptr;
    logic [ADDRESS_SIZE:0] w_bnext;
    logic [ADDRESS_SIZE:0] w_gnext;

    function automatic logic [ADDRESS_SIZE:0] bin2gray(input logic [ADDRESS_SIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    two_ff_synchronizer #(
        .WIDTH (ADDRESS_SIZE + 1)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (rrst_n),
        .i_d   (w_ptr),
        .o_q   (w_rq2_wptr)
    );

    // A fetch is issued to fill an empty output stage, or to refill it as the
    // consumer takes the current word, so streaming has no bubble.
    assign r_mem_en = !r_empty && ((r_state == ST_IDLE) || ((r_state == ST_VALID) && r_en));
    assign w_bnext  = r_bin + {{ADDRESS_SIZE{1'b0}}, r_mem_en};
    assign w_gnext  = bin2gray(w_bnext);
    assign r_addr   = r_bin[ADDRESS_SIZE-1:0];
    assign r_data   = r_mem_data;

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin   <= '0;
            r_ptr   <= '0;
            r_empty <= 1'b1;
        end else begin
            r_bin   <= w_bnext;
            r_ptr   <= w_gnext;
            r_empty <= (w_gnext == w_rq2_wptr);
        end
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_mem_en) begin
                        r_state <= ST_VALID;
                        r_valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (r_en && r_empty) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef R_ALMOST_EMPTY_EN
    localparam logic [ADDRESS_SIZE:0] C_AE_THRESHOLD = (ADDRESS_SIZE + 1)'(AE_THRESHOLD);

    logic [ADDRESS_SIZE:0] w_rq2_wbin;
    logic [ADDRESS_SIZE:0] w_fill;

    function automatic logic [ADDRESS_SIZE:0] gray2bin(input logic [ADDRESS_SIZE:0] g);
        logic [ADDRESS_SIZE:0] b;
        b[ADDRESS_SIZE] = g[ADDRESS_SIZE];
        for (int i = ADDRESS_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Unfetched words only; the word already presented on r_data is not counted.
    assign w_rq2_wbin = gray2bin(w_rq2_wptr);
    assign w_fill     = w_rq2_wbin - w_bnext;

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_empty <= (w_fill <= C_AE_THRESHOLD);
        end
    end
`else
    assign r_almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_r_clk_fwft_module.sv
`default_nettype none
// Directed bench for r_clk_fwft_module (ADDRESS_SIZE=4, DATA_SIZE=8) with a
// registered-output RAM model on the read port.
module tb_r_clk_fwft_module;

    logic       r_clk = 1'b0;
    logic       rrst_n;
    logic [4:0] w_ptr;
    logic [7:0] r_mem_data;
    logic       r_en;
    logic       r_mem_en;
    logic [3:0] r_addr;
    logic [4:0] r_ptr;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_empty;
    logic       r_almost_empty;

    logic [7:0] mem [16];
    int         n_vec = 0;
    int         n_err = 0;
    logic       ae_hi;

    r_clk_fwft_module #(
        .ADDRESS_SIZE (4),
        .DATA_SIZE    (8),
        .AE_THRESHOLD (2)
    ) dut (
        .r_clk          (r_clk),
        .rrst_n         (rrst_n),
        .w_ptr          (w_ptr),
        .r_mem_data     (r_mem_data),
        .r_en           (r_en),
        .r_mem_en       (r_mem_en),
        .r_addr         (r_addr),
        .r_ptr          (r_ptr),
        .r_data         (r_data),
        .r_valid        (r_valid),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) begin
        if (r_mem_en) r_mem_data <= mem[r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int c = 0; c < budget && !r_valid; c++) tick();
        chk("wait_valid", {31'd0, r_valid}, 32'd1);
    endtask

    task automatic drain(input int start, input int n, input logic [4:0] end_ptr);
        int reads    = 0;
        int valids   = 0;
        int run      = 0;
        int maxrun   = 0;
        int consumed = start;
        r_en = 1'b1;
        for (int c = 0; c < 60 && !(reads == n && !r_valid); c++) begin
            if (r_mem_en) begin
                chk("drain_addr", {28'd0, r_addr}, (start + reads) % 16);
                reads++;
            end
            if (r_valid) begin
                chk("drain_data", {24'd0, r_data}, {24'd0, mem[consumed % 16]});
                consumed++;
                valids++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            tick();
        end
        r_en = 1'b0;
        chk("drain_reads", reads, n);
        chk("drain_valids", valids, n);
        chk("drain_run", maxrun, n);
        chk("drain_ptr", {27'd0, r_ptr}, {27'd0, end_ptr});
        chk("drain_empty", {31'd0, r_empty}, 32'd1);
        chk("drain_valid", {31'd0, r_valid}, 32'd0);
    endtask

    initial begin
`ifdef R_ALMOST_EMPTY_EN
        ae_hi = 1'b1;
`else
        ae_hi = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
        mem[0]     = 8'hA5;
        r_mem_data = 8'h00;
        rrst_n     = 1'b0;
        w_ptr      = 5'b00000;
        r_en       = 1'b0;
        tick();
        tick();

        chk("rst_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_empty", {31'd0, r_empty}, 32'd1);
        chk("rst_ptr", {27'd0, r_ptr}, 32'd0);
        chk("rst_addr", {28'd0, r_addr}, 32'd0);
        chk("rst_memen", {31'd0, r_mem_en}, 32'd0);
        chk("rst_ae", {31'd0, r_almost_empty}, {31'd0, ae_hi});

        rrst_n = 1'b1;
        tick();
        tick();
        chk("idle_empty", {31'd0, r_empty}, 32'd1);

        // Single word: latency and consume
        w_ptr = 5'b00001;
        tick();
        tick();
        chk("lat_e2_empty", {31'd0, r_empty}, 32'd1);
        tick();
        chk("lat_e3_empty", {31'd0, r_empty}, 32'd0);
        chk("lat_e3_memen", {31'd0, r_mem_en}, 32'd1);
        chk("lat_e3_addr", {28'd0, r_addr}, 32'd0);
        chk("lat_e3_valid", {31'd0, r_valid}, 32'd0);
        tick();
        chk("lat_e4_valid", {31'd0, r_valid}, 32'd1);
        chk("lat_e4_data", {24'd0, r_data}, 32'hA5);
        chk("lat_e4_ptr", {27'd0, r_ptr}, 32'b00001);
        chk("lat_e4_empty", {31'd0, r_empty}, 32'd1);
        r_en = 1'b1;
        #1;
        chk("pop_memen", {31'd0, r_mem_en}, 32'd0);
        tick();
        r_en = 1'b0;
        chk("pop_valid", {31'd0, r_valid}, 32'd0);
        chk("pop_ptr", {27'd0, r_ptr}, 32'b00001);

        // Reset while a word is held
        w_ptr = 5'b00010;
        wait_valid(20);
        rrst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, r_valid}, 32'd0);
        chk("mrst_empty", {31'd0, r_empty}, 32'd1);
        chk("mrst_ptr", {27'd0, r_ptr}, 32'd0);
        chk("mrst_addr", {28'd0, r_addr}, 32'd0);
        chk("mrst_memen", {31'd0, r_mem_en}, 32'd0);
        w_ptr = 5'b00000;
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_valid", {31'd0, r_valid}, 32'd0);
        chk("post_rst_empty", {31'd0, r_empty}, 32'd1);

        // Full 16-word stream, then 4 more across the address wrap
        w_ptr = 5'b11000;
        drain(0, 16, 5'b11000);
        w_ptr = 5'b11110;
        drain(16, 4, 5'b11110);

        // Stall with words pending: output and pointer must hold
        w_ptr = 5'b10100;
        r_en  = 1'b0;
        wait_valid(20);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("hold_memen", {31'd0, r_mem_en}, 32'd0);
            chk("hold_data", {24'd0, r_data}, 32'h34);
            chk("hold_ptr", {27'd0, r_ptr}, 32'b11111);
            chk("hold_valid", {31'd0, r_valid}, 32'd1);
            tick();
        end

        // Almost-empty with 5 words
        rrst_n = 1'b0;
        #1;
        chk("ae_rst", {31'd0, r_almost_empty}, {31'd0, ae_hi});
        w_ptr = 5'b00000;
        tick();
        rrst_n = 1'b1;
        tick();
        w_ptr = 5'b00111;
        tick();
        tick();
        tick();
        chk("ae_fill_empty", {31'd0, r_empty}, 32'd0);
        chk("ae_fill", {31'd0, r_almost_empty}, 32'd0);
        drain(0, 5, 5'b00111);
        chk("ae_drained", {31'd0, r_almost_empty}, {31'd0, ae_hi});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
